// File: rtl/banco_registradores_param.sv
// -----------------------------------------------------------------------------
// banco_registradores_param
//
// Parametrised register bank feeding the two ALU operand paths. It has one
// synchronous write port and two independent read ports, A and B.
//
// Features:
//   - write-to-read bypass (BYPASS)
//   - optional registered read outputs (LEITURA_REGISTRADA)
//   - hardwired-zero register 0 (ZERO_R0)
//   - synchronous bank clear (limpar)
//
// Parameters:
//   LARGURA            data width of each register and of every data port
//   NUM_REGS           number of registers, 2..64 (need not be a power of 2)
//   LARGURA_END        address width, must equal $clog2(NUM_REGS)
//   LEITURA_REGISTRADA 0: combinational reads, 1: reads registered (1 cycle)
//   BYPASS             1: a read of the register being written returns the
//                      new data in the same cycle
//   ZERO_R0            1: register 0 always reads 0 and ignores writes
//
// Ports:
//   clock               in   rising-edge clock
//   resetn              in   asynchronous reset, active-low
//   limpar              in   synchronous clear of every register
//   escrita_en          in   write enable
//   endereco_escrita    in   write address
//   dado_escrita        in   write data
//   endereco_leitura_a  in   read address, port A
//   endereco_leitura_b  in   read address, port B
//   saida_a             out  read data, port A
//   saida_b             out  read data, port B
// -----------------------------------------------------------------------------
module banco_registradores_param #(
    parameter int LARGURA            = 16,
    parameter int NUM_REGS           = 8,
    parameter int LARGURA_END        = 3,
    parameter int LEITURA_REGISTRADA = 0,
    parameter int BYPASS             = 1,
    parameter int ZERO_R0            = 0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   limpar,
    input  logic                   escrita_en,
    input  logic [LARGURA_END-1:0] endereco_escrita,
    input  logic [LARGURA-1:0]     dado_escrita,
    input  logic [LARGURA_END-1:0] endereco_leitura_a,
    input  logic [LARGURA_END-1:0] endereco_leitura_b,
    output logic [LARGURA-1:0]     saida_a,
    output logic [LARGURA-1:0]     saida_b
);

    // The register count is widened by one bit so that the range check also
    // works when NUM_REGS is exactly 2**LARGURA_END.
    localparam logic [LARGURA_END:0] NUM_REGS_W = (LARGURA_END + 1)'(NUM_REGS);

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    logic end_escrita_no_banco;
    logic escrita_em_r0_fixo;
    logic escrita_valida;

    assign end_escrita_no_banco = ({1'b0, endereco_escrita} < NUM_REGS_W);
    assign escrita_em_r0_fixo   = (ZERO_R0 != 0) && (endereco_escrita == '0);
    assign escrita_valida       = escrita_en && end_escrita_no_banco && !escrita_em_r0_fixo;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    // Each register is its own flop group, because the asynchronous reset
    // and the single-cycle clear both have to touch every entry at once.
    logic [LARGURA-1:0] banco [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
            if ((ZERO_R0 != 0) && (gi == 0)) begin : gen_zero
                // Register 0 is hardwired to zero.
                // No storage is built for it.
                assign banco[gi] = '0;
            end else begin : gen_ff
                localparam logic [LARGURA_END-1:0] INDICE = LARGURA_END'(gi);
                logic [LARGURA-1:0] valor_reg;

                // limpar takes priority over a write in the same cycle.
                always_ff @(posedge clock or negedge resetn) begin
                    if (!resetn) begin
                        valor_reg <= '0;
                    end else if (limpar) begin
                        valor_reg <= '0;
                    end else if (escrita_valida && (endereco_escrita == INDICE)) begin
                        valor_reg <= dado_escrita;
                    end
                end

                assign banco[gi] = valor_reg;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Both ports are built from the same template: index 0 is A, index 1 is B.
    logic [LARGURA_END-1:0] endereco_leitura [2];
    logic [LARGURA-1:0]     saida_porta      [2];

    assign endereco_leitura[0] = endereco_leitura_a;
    assign endereco_leitura[1] = endereco_leitura_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_porta
            logic [LARGURA-1:0] valor_armazenado;
            logic [LARGURA-1:0] valor_leitura;

            // N:1 read mux.
            // Addresses at or above NUM_REGS match no entry, so they read 0.
            // An out-of-range address can therefore never produce X.
            always_comb begin
                valor_armazenado = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (endereco_leitura[gi] == LARGURA_END'(i)) begin
                        valor_armazenado = banco[i];
                    end
                end
            end

            if (BYPASS != 0) begin : gen_bypass
                // Forward the value the bank will hold after this edge.
                // The write qualification already rejects out-of-range
                // addresses and the fixed R0, so those never forward.
                always_comb begin
                    valor_leitura = valor_armazenado;
                    if (limpar) begin
                        valor_leitura = '0;
                    end else if (escrita_valida &&
                                 (endereco_leitura[gi] == endereco_escrita)) begin
                        valor_leitura = dado_escrita;
                    end
                end
            end else begin : gen_sem_bypass
                assign valor_leitura = valor_armazenado;
            end

            if (LEITURA_REGISTRADA != 0) begin : gen_saida_reg
                logic [LARGURA-1:0] saida_reg;

                always_ff @(posedge clock or negedge resetn) begin
                    if (!resetn) begin
                        saida_reg <= '0;
                    end else begin
                        saida_reg <= valor_leitura;
                    end
                end

                assign saida_porta[gi] = saida_reg;
            end else begin : gen_saida_comb
                // Mask the output while reset is low.
                // Otherwise a bypassed write could still show through
                // during reset.
                assign saida_porta[gi] = resetn ? valor_leitura : '0;
            end
        end
    endgenerate

    assign saida_a = saida_porta[0];
    assign saida_b = saida_porta[1];

endmodule

// File: tb/tb_banco_registradores_param.sv
// -----------------------------------------------------------------------------
// tb_banco_registradores_param
//
// Five differently parametrised instances share one stimulus bus:
//   0 default    combinational reads, bypass on
//   1 registered registered reads, bypass on
//   2 no bypass  combinational reads, bypass off
//   3 zero R0    register 0 hardwired to zero
//   4 six regs   NUM_REGS = 6
//
// The stimulus pushes hand-computed expectations, each tagged with the cycle
// in which it is due. A monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_banco_registradores_param;

    logic        clock;
    logic        resetn;
    logic        limpar;
    logic        escrita_en;
    logic [2:0]  endereco_escrita;
    logic [15:0] dado_escrita;
    logic [2:0]  endereco_leitura_a;
    logic [2:0]  endereco_leitura_b;
    logic [15:0] sa [5];
    logic [15:0] sb [5];

    int cyc;
    int tests_run;
    int tests_failed;

    typedef struct {
        int          due;
        int          inst;
        logic [15:0] a;
        logic [15:0] b;
        string       nm;
    } sb_t;

    sb_t q [$];

    // ------------------------------------------------------------------
    // DUT instances
    // ------------------------------------------------------------------
    banco_registradores_param #(
        .LARGURA(16), .NUM_REGS(8), .LARGURA_END(3),
        .LEITURA_REGISTRADA(0), .BYPASS(1), .ZERO_R0(0)
    ) u_comb (
        .clock(clock), .resetn(resetn), .limpar(limpar), .escrita_en(escrita_en),
        .endereco_escrita(endereco_escrita), .dado_escrita(dado_escrita),
        .endereco_leitura_a(endereco_leitura_a), .endereco_leitura_b(endereco_leitura_b),
        .saida_a(sa[0]), .saida_b(sb[0])
    );

    banco_registradores_param #(
        .LARGURA(16), .NUM_REGS(8), .LARGURA_END(3),
        .LEITURA_REGISTRADA(1), .BYPASS(1), .ZERO_R0(0)
    ) u_reg (
        .clock(clock), .resetn(resetn), .limpar(limpar), .escrita_en(escrita_en),
        .endereco_escrita(endereco_escrita), .dado_escrita(dado_escrita),
        .endereco_leitura_a(endereco_leitura_a), .endereco_leitura_b(endereco_leitura_b),
        .saida_a(sa[1]), .saida_b(sb[1])
    );

    banco_registradores_param #(
        .LARGURA(16), .NUM_REGS(8), .LARGURA_END(3),
        .LEITURA_REGISTRADA(0), .BYPASS(0), .ZERO_R0(0)
    ) u_nobyp (
        .clock(clock), .resetn(resetn), .limpar(limpar), .escrita_en(escrita_en),
        .endereco_escrita(endereco_escrita), .dado_escrita(dado_escrita),
        .endereco_leitura_a(endereco_leitura_a), .endereco_leitura_b(endereco_leitura_b),
        .saida_a(sa[2]), .saida_b(sb[2])
    );

    banco_registradores_param #(
        .LARGURA(16), .NUM_REGS(8), .LARGURA_END(3),
        .LEITURA_REGISTRADA(0), .BYPASS(1), .ZERO_R0(1)
    ) u_z0 (
        .clock(clock), .resetn(resetn), .limpar(limpar), .escrita_en(escrita_en),
        .endereco_escrita(endereco_escrita), .dado_escrita(dado_escrita),
        .endereco_leitura_a(endereco_leitura_a), .endereco_leitura_b(endereco_leitura_b),
        .saida_a(sa[3]), .saida_b(sb[3])
    );

    banco_registradores_param #(
        .LARGURA(16), .NUM_REGS(6), .LARGURA_END(3),
        .LEITURA_REGISTRADA(0), .BYPASS(1), .ZERO_R0(0)
    ) u_six (
        .clock(clock), .resetn(resetn), .limpar(limpar), .escrita_en(escrita_en),
        .endereco_escrita(endereco_escrita), .dado_escrita(dado_escrita),
        .endereco_leitura_a(endereco_leitura_a), .endereco_leitura_b(endereco_leitura_b),
        .saida_a(sa[4]), .saida_b(sb[4])
    );

    // ------------------------------------------------------------------
    // Clock and cycle counter
    // ------------------------------------------------------------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: on each falling edge, compare every expectation due now
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        sb_t keep [$];
        sb_t e;
        keep.delete();
        for (int k = 0; k < q.size(); k++) begin
            e = q[k];
            if (e.due == cyc) begin
                tests_run++;
                if (sa[e.inst] !== e.a || sb[e.inst] !== e.b) begin
                    tests_failed++;
                    $display("[TB] FAIL %s inst%0d cyc%0d: got a=%h b=%h, expected a=%h b=%h",
                             e.nm, e.inst, cyc, sa[e.inst], sb[e.inst], e.a, e.b);
                end else begin
                    $display("[TB] ok   %s inst%0d cyc%0d: a=%h b=%h",
                             e.nm, e.inst, cyc, sa[e.inst], sb[e.inst]);
                end
            end else if (e.due < cyc) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL %s inst%0d: expectation missed (due %0d, now %0d)",
                         e.nm, e.inst, e.due, cyc);
            end else begin
                keep.push_back(e);
            end
        end
        q = keep;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Queue an expectation for instance inst, due lat cycles from now.
    task automatic expect_val(input int inst, input string nm,
                              input logic [15:0] a, input logic [15:0] b,
                              input int lat);
        sb_t e;
        e.due  = cyc + lat;
        e.inst = inst;
        e.a    = a;
        e.b    = b;
        e.nm   = nm;
        q.push_back(e);
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb);
        escrita_en         = we;
        endereco_escrita   = wa;
        dado_escrita       = wd;
        endereco_leitura_a = ra;
        endereco_leitura_b = rb;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    logic [15:0] six_exp [6];
    logic [15:0] va;
    logic [15:0] vb;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        limpar       = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);

        // Reset state: outputs read 0 while reset is held, even with a write pending.
        tick();
        drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3);
        for (int n = 0; n < 5; n++) expect_val(n, "reset_hold", 16'h0000, 16'h0000, 0);
        @(negedge clock);
        #1;
        resetn = 1'b1;
        escrita_en = 1'b0;

        // 1: write R3 = BEEF, then pulse reset between edges.
        tick();
        drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3);
        expect_val(0, "t1_bypass",     16'hBEEF, 16'hBEEF, 0);
        expect_val(2, "t1_nobyp_old",  16'h0000, 16'h0000, 0);
        expect_val(1, "t1_reg_delay",  16'hBEEF, 16'hBEEF, 1);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);
        expect_val(0, "t1_stored",     16'hBEEF, 16'hBEEF, 0);
        expect_val(2, "t1_nobyp_next", 16'hBEEF, 16'hBEEF, 0);
        tick();
        #1;
        resetn = 1'b0;
        for (int n = 0; n < 3; n++) expect_val(n, "t1_async_rst", 16'h0000, 16'h0000, 0);
        @(negedge clock);
        #1;
        resetn = 1'b1;
        tick();
        expect_val(0, "t1_after_rst", 16'h0000, 16'h0000, 0);
        expect_val(2, "t1_after_rst", 16'h0000, 16'h0000, 0);

        // 2: write 0x1111*i to Ri, reading the same address (bypass path).
        for (int i = 0; i < 8; i++) begin
            tick();
            va = 16'(16'h1111 * i);
            drive(1'b1, 3'(i), va, 3'(i), 3'(i));
            expect_val(0, "t2_wr_bypass", va, va, 0);
            expect_val(2, "t2_wr_nobyp", 16'h0000, 16'h0000, 0);
            expect_val(1, "t2_wr_reg", va, va, 1);
            expect_val(3, "t2_wr_z0", (i == 0) ? 16'h0000 : va, (i == 0) ? 16'h0000 : va, 0);
            expect_val(4, "t2_wr_six", (i < 6) ? va : 16'h0000, (i < 6) ? va : 16'h0000, 0);
        end

        //    Sweep A=i, B=7-i.
        for (int i = 0; i < 8; i++) begin
            tick();
            va = 16'(16'h1111 * i);
            vb = 16'(16'h1111 * (7 - i));
            drive(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));
            expect_val(0, "t2_sweep", va, vb, 0);
            expect_val(2, "t2_sweep_nobyp", va, vb, 0);
            expect_val(1, "t2_sweep_reg", va, vb, 1);
            expect_val(3, "t2_sweep_z0", (i == 0) ? 16'h0000 : va, (i == 7) ? 16'h0000 : vb, 0);
            expect_val(4, "t2_sweep_six", (i < 6) ? va : 16'h0000, (i > 1) ? vb : 16'h0000, 0);
        end

        // 3: bypass with R5 = 0001 and a same-cycle write of A5A5.
        tick();
        drive(1'b1, 3'd5, 16'h0001, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd5, 16'hA5A5, 3'd5, 3'd5);
        expect_val(0, "t3_bypass",     16'hA5A5, 16'hA5A5, 0);
        expect_val(2, "t3_nobyp_old",  16'h0001, 16'h0001, 0);
        expect_val(1, "t3_reg_bypass", 16'hA5A5, 16'hA5A5, 1);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 3'd5, 3'd5);
        expect_val(0, "t3_stored",     16'hA5A5, 16'hA5A5, 0);
        expect_val(2, "t3_nobyp_next", 16'hA5A5, 16'hA5A5, 0);

        // 4: write FFFF to R0; the hardwired R0 stays 0, also while bypassing.
        tick();
        drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
        expect_val(3, "t4_z0_bypass", 16'h0000, 16'h0000, 0);
        expect_val(0, "t4_r0_bypass", 16'hFFFF, 16'hFFFF, 0);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        expect_val(3, "t4_z0_stored", 16'h0000, 16'h0000, 0);
        expect_val(0, "t4_r0_stored", 16'hFFFF, 16'hFFFF, 0);

        // 5: with six registers, writes to 6 and 7 are ignored.
        tick();
        drive(1'b1, 3'd6, 16'h1234, 3'd6, 3'd5);
        expect_val(4, "t5_six_wr6", 16'h0000, 16'hA5A5, 0);
        expect_val(0, "t5_def_wr6", 16'h1234, 16'hA5A5, 0);
        tick();
        drive(1'b1, 3'd7, 16'h1234, 3'd7, 3'd6);
        expect_val(4, "t5_six_wr7", 16'h0000, 16'h0000, 0);
        expect_val(0, "t5_def_wr7", 16'h1234, 16'h1234, 0);
        six_exp = '{16'hFFFF, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hA5A5};
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(1'b0, 3'd0, 16'h0000, 3'(i), 3'd5);
            expect_val(4, "t5_six_keep", six_exp[i], 16'hA5A5, 0);
        end
        tick();
        drive(1'b0, 3'd0, 16'h0000, 3'd6, 3'd7);
        expect_val(4, "t5_six_oob", 16'h0000, 16'h0000, 0);
        expect_val(0, "t5_def_67",  16'h1234, 16'h1234, 0);

        // 6: limpar together with a write to R2.
        tick();
        limpar = 1'b1;
        drive(1'b1, 3'd2, 16'h7777, 3'd2, 3'd3);
        expect_val(0, "t6_clr_bypass", 16'h0000, 16'h0000, 0);
        expect_val(2, "t6_clr_nobyp",  16'h2222, 16'h3333, 0);
        expect_val(1, "t6_clr_reg",    16'h0000, 16'h0000, 1);
        tick();
        limpar = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 3'd2, 3'd3);
        expect_val(0, "t6_cleared", 16'h0000, 16'h0000, 0);
        expect_val(2, "t6_cleared", 16'h0000, 16'h0000, 0);
        expect_val(3, "t6_cleared", 16'h0000, 16'h0000, 0);
        expect_val(4, "t6_cleared", 16'h0000, 16'h0000, 0);
        expect_val(1, "t6_cleared", 16'h0000, 16'h0000, 1);

        tick();
        tick();
        tick();
        if (q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
